// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage to multiply/divide sequencer signal bundle (MDU_CANCEL_EN adds cancel)
interface mdu_ctrl_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        hilo_use_d;
`ifdef MDU_CANCEL_EN
   logic        cancel;
`endif
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, src_a, src_b, mthi, mtlo, wdata, hilo_use_d,
`ifdef MDU_CANCEL_EN
      output cancel,
`endif
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, mthi, mtlo, wdata, hilo_use_d,
`ifdef MDU_CANCEL_EN
      input  cancel,
`endif
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide sequencer with HI/LO pair and D-stage stall (MDU_CANCEL_EN adds cancel)
module mdu_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input logic       clk,
   input logic       rst_n,
   mdu_ctrl_if.slave bus
);
   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [31:0]        res_hi, res_lo;
   logic [31:0]        calc_hi, calc_lo;
   logic               accept, commit, mt_write, cancel_req;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               ovf_s;
   logic signed [31:0] div_b_s, quot_s, rem_s;
   logic [31:0]        div_b_u, quot_u, rem_u;

`ifdef MDU_CANCEL_EN
   assign cancel_req = bus.cancel;
`else
   assign cancel_req = 1'b0;
`endif

   // Both products are formed at full 64-bit width so no bits are lost.
   assign prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) * $signed({{32{bus.src_b[31]}}, bus.src_b});
   assign prod_u = {32'b0, bus.src_a} * {32'b0, bus.src_b};

   // Zero divisor and the single signed overflow case are steered to a divide by one,
   // which leaves the divider well defined and yields the overflow result directly.
   assign ovf_s   = (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);
   assign div_b_s = ((bus.src_b == 32'd0) || ovf_s) ? 32'sd1 : $signed(bus.src_b);
   assign div_b_u = (bus.src_b == 32'd0) ? 32'd1 : bus.src_b;
   assign quot_s  = $signed(bus.src_a) / div_b_s;
   assign rem_s   = $signed(bus.src_a) % div_b_s;
   assign quot_u  = bus.src_a / div_b_u;
   assign rem_u   = bus.src_a % div_b_u;

   // Select the result for the issued op; divide by zero gives all-ones quotient and dividend remainder.
   always_comb begin
      calc_hi = 32'd0;
      calc_lo = 32'd0;
      case (bus.op)
         2'd0: {calc_hi, calc_lo} = prod_s;
         2'd1: {calc_hi, calc_lo} = prod_u;
         2'd2: begin
            if (bus.src_b == 32'd0) begin
               calc_hi = bus.src_a;
               calc_lo = 32'hFFFF_FFFF;
            end else begin
               calc_hi = rem_s;
               calc_lo = quot_s;
            end
         end
         default: begin
            if (bus.src_b == 32'd0) begin
               calc_hi = bus.src_a;
               calc_lo = 32'hFFFF_FFFF;
            end else begin
               calc_hi = rem_u;
               calc_lo = quot_u;
            end
         end
      endcase
   end

   // Next-state: accept an issue in IDLE, count down in BUSY, commit when the count reaches zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !cancel_req) begin
               accept    = 1'b1;
               state_nxt = BUSY;
               cnt_nxt   = bus.op[1] ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
            end
         end
         BUSY: begin
            if (cancel_req) begin
               state_nxt = IDLE;
            end else if (cnt == '0) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A move in the same cycle as an issue loses to the issue.
   assign mt_write = (state == IDLE) && !bus.start;

   // State and latency counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Capture the result of an accepted operation until it is committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else if (accept) begin
         res_hi <= calc_hi;
         res_lo <= calc_lo;
      end
   end

   // Architectural HI/LO, registered busy and the one-cycle commit pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.hi   <= 32'd0;
         bus.lo   <= 32'd0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.busy <= (state_nxt == BUSY);
         bus.done <= commit;
         if (commit) begin
            bus.hi <= res_hi;
            bus.lo <= res_lo;
         end else if (mt_write) begin
            if (bus.mthi) bus.hi <= bus.wdata;
            if (bus.mtlo) bus.lo <= bus.wdata;
         end
      end
   end

   assign bus.stall = bus.hilo_use_d & (bus.busy | bus.start);

   // Issues and moves are held in D while an operation is in flight.
   a_no_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
      (state == BUSY) |-> !(bus.start || bus.mthi || bus.mtlo));

   // An issue never shares its cycle with a move.
   a_no_start_with_move: assert property (@(posedge clk) disable iff (!rst_n)
      (state == IDLE && bus.start) |-> !(bus.mthi || bus.mtlo));
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl with a longint arithmetic reference model
module tb_mdu_ctrl;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        sb[$];
   exp_t        mon_x;
   logic [31:0] model_hi, model_lo;

   mdu_ctrl_if mdu_bus ();

   mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mdu_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, returns {hi, lo}.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sbv, q, r, p;
      longint unsigned ua, ub, uq, ur;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (o)
         2'd0: begin p = sa * sbv; return p; end
         2'd1: return ua * ub;
         2'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sbv;
            r = sa - q * sbv;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua - uq * ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      int unsigned sel;
      sel = $urandom_range(0, 5);
      case (sel)
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      exp_t        x;
      @(posedge clk); #1;
      mdu_bus.start = 1'b1;
      mdu_bus.op    = o;
      mdu_bus.src_a = a;
      mdu_bus.src_b = b;
      e     = model(o, a, b);
      x.hi  = e[63:32];
      x.lo  = e[31:0];
      x.due = cyc + (o[1] ? DIV_LAT : MULT_LAT) + 1;
      sb.push_back(x);
      model_hi = x.hi;
      model_lo = x.lo;
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      drive_start(o, a, b);
      @(posedge clk); #1;
      mdu_bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (mdu_bus.busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_idle_busy", mdu_bus.busy, 0);
   endtask

   task automatic move(input logic h, input logic l, input logic [31:0] d);
      @(posedge clk); #1;
      mdu_bus.mthi  = h;
      mdu_bus.mtlo  = l;
      mdu_bus.wdata = d;
      if (h) model_hi = d;
      if (l) model_lo = d;
      @(posedge clk); #1;
      mdu_bus.mthi = 1'b0;
      mdu_bus.mtlo = 1'b0;
      check("move_hi", mdu_bus.hi, model_hi);
      check("move_lo", mdu_bus.lo, model_lo);
   endtask

   // Monitor: every done pulse retires the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mdu_bus.done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
               mon_x = sb.pop_front();
               check("commit_hi", mdu_bus.hi, mon_x.hi);
               check("commit_lo", mdu_bus.lo, mon_x.lo);
               check("commit_cycle", cyc, mon_x.due);
            end
         end else if (sb.size() > 0 && cyc > sb[0].due) begin
            total++;
            bad++;
            $display("FAIL done_missing: got no done expected at cycle %0d", sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      logic [1:0]  o;
      logic [31:0] a, b, sv_hi, sv_lo;

      rst_n              = 1'b0;
      mdu_bus.start      = 1'b0;
      mdu_bus.op         = 2'd0;
      mdu_bus.src_a      = 32'd0;
      mdu_bus.src_b      = 32'd0;
      mdu_bus.mthi       = 1'b0;
      mdu_bus.mtlo       = 1'b0;
      mdu_bus.wdata      = 32'd0;
      mdu_bus.hilo_use_d = 1'b0;
`ifdef MDU_CANCEL_EN
      mdu_bus.cancel     = 1'b0;
`endif
      model_hi = 32'd0;
      model_lo = 32'd0;

      #2;
      check("reset_hi", mdu_bus.hi, 0);
      check("reset_lo", mdu_bus.lo, 0);
      check("reset_busy", mdu_bus.busy, 0);
      check("reset_done", mdu_bus.done, 0);
      check("reset_stall", mdu_bus.stall, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // MULT -2*3 with hilo_use_d held from the start cycle.
      drive_start(2'd0, 32'hFFFF_FFFE, 32'd3);
      mdu_bus.hilo_use_d = 1'b1;
      @(negedge clk);
      check("stall_start_cycle", mdu_bus.stall, 1);
      check("busy_start_cycle", mdu_bus.busy, 0);
      for (int i = 1; i <= MULT_LAT; i++) begin
         @(posedge clk); #1;
         mdu_bus.start = 1'b0;
         @(negedge clk);
         check("busy_in_flight", mdu_bus.busy, 1);
         check("stall_in_flight", mdu_bus.stall, 1);
      end
      @(negedge clk);
      check("busy_done_cycle", mdu_bus.busy, 0);
      check("stall_done_cycle", mdu_bus.stall, 0);
      check("done_pulse", mdu_bus.done, 1);
      check("mult_hi", mdu_bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", mdu_bus.lo, 32'hFFFF_FFFA);
      mdu_bus.hilo_use_d = 1'b0;

      issue(2'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle();
      check("multu_hi", mdu_bus.hi, 32'h0000_0002);
      check("multu_lo", mdu_bus.lo, 32'hFFFF_FFFA);

      issue(2'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      check("div_hi", mdu_bus.hi, 32'hFFFF_FFFF);
      check("div_lo", mdu_bus.lo, 32'hFFFF_FFFD);

      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("div_ovf_hi", mdu_bus.hi, 32'h0);
      check("div_ovf_lo", mdu_bus.lo, 32'h8000_0000);

      issue(2'd3, 32'd7, 32'd0);
      wait_idle();
      check("divu0_hi", mdu_bus.hi, 32'd7);
      check("divu0_lo", mdu_bus.lo, 32'hFFFF_FFFF);

      move(1'b1, 1'b0, 32'h0000_1234);
      check("mthi_value", mdu_bus.hi, 32'h0000_1234);
      move(1'b1, 1'b1, 32'hCAFE_0001);

      // Second issue lands in the done cycle of the first.
      issue(2'd0, 32'd6, 32'd7);
      repeat (MULT_LAT - 1) @(posedge clk);
      issue(2'd1, 32'd100, 32'd3);
      check("back_to_back_busy", mdu_bus.busy, 1);
      wait_idle();

`ifdef MDU_CANCEL_EN
      sv_hi = model_hi;
      sv_lo = model_lo;
      issue(2'd2, 32'd1000, 32'd7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      mdu_bus.cancel = 1'b1;
      @(posedge clk); #1;
      mdu_bus.cancel = 1'b0;
      sb.delete();
      model_hi = sv_hi;
      model_lo = sv_lo;
      check("cancel_busy", mdu_bus.busy, 0);
      repeat (DIV_LAT + 2) @(posedge clk);
      #1;
      check("cancel_hi", mdu_bus.hi, sv_hi);
      check("cancel_lo", mdu_bus.lo, sv_lo);
`endif

      for (int n = 0; n < 40; n++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         issue(o, a, b);
         wait_idle();
         if ($urandom_range(0, 2) == 0)
            move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom()));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Asynchronous reset in the middle of a divide.
      issue(2'd3, 32'd100, 32'd7);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_hi", mdu_bus.hi, 0);
      check("midreset_lo", mdu_bus.lo, 0);
      check("midreset_busy", mdu_bus.busy, 0);
      check("midreset_done", mdu_bus.done, 0);
      sb.delete();
      model_hi = 32'd0;
      model_lo = 32'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (DIV_LAT + 2) @(posedge clk);
      #1;
      check("post_reset_hi", mdu_bus.hi, 0);
      check("post_reset_busy", mdu_bus.busy, 0);

      repeat (5) @(posedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the multi-cycle multiply/divide unit and the HI/LO register pair in the 5-stage MIPS pipeline.
- Accepts mult/div issue from the E stage and runs a latency counter.
- Commits results to HI/LO and supports mthi/mtlo writes.
- Generates the D-stage stall used by the hazard/stall logic when an instruction touching HI/LO meets an in-flight operation.

Parameters:
MULT_LAT, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
DIV_LAT, 10, cycles from accepted div/divu to HI/LO commit (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  E-stage mult/multu/div/divu issue, one-cycle pulse per instruction
op  in  2  0=MULT 1=MULTU 2=DIV 3=DIVU, valid with start
src_a  in  32  rs value (forwarded)
src_b  in  32  rt value (forwarded)
mthi  in  1  E-stage mthi write
mtlo  in  1  E-stage mtlo write
wdata  in  32  data for mthi/mtlo
hilo_use_d  in  1  D-stage instr is mfhi/mflo/mthi/mtlo/mult/multu/div/divu
busy  out  1  operation in flight
stall  out  1  freeze PC/IR_D, bubble into E
done  out  1  one-cycle pulse on HI/LO commit
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0; stall=0 combinationally.
- States:
  - IDLE: start=1 -> BUSY. Operands latched, result computed into internal res_hi/res_lo; counter=LAT-1 (MULT_LAT for op 0/1, DIV_LAT for op 2/3).
  - BUSY: counter decrements each cycle. At counter==0 the clock edge writes hi<=res_hi, lo<=res_lo, done<=1, state->IDLE.
- Timing: start at edge t gives busy=1 over cycles t+1..t+LAT, HI/LO new from t+LAT+1, done=1 in cycle t+LAT+1 only.
- busy is registered. stall = hilo_use_d & (busy | start), combinational.
- Arithmetic:
  - MULT: signed 32x32->64, hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32->64, same split.
  - DIV: signed, truncate toward zero, lo=quotient, hi=remainder (sign of dividend).
  - DIVU: unsigned, lo=quotient, hi=remainder.
- Boundary cases:
  - Divide by zero (any sign): lo=32'hFFFFFFFF, hi=src_a, full latency still spent.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - mthi/mtlo in IDLE: register written at that edge, visible next cycle. Both asserted together: both written with wdata.
  - mthi/mtlo or start while BUSY: ignored, state unchanged. Cannot happen legally because stall holds them in D; simulation assertion flags it.
  - start and mthi/mtlo in the same IDLE cycle: start wins, move ignored, assertion.
  - Back-to-back: start in the done cycle (state IDLE) is accepted normally.
  - Reset mid-operation: aborts immediately; hi/lo=0, no done pulse.

Optional Feature:
MDU_CANCEL_EN
- With it: input cancel (1 bit, exception/flush). cancel=1 in BUSY -> state IDLE at next edge, HI/LO unchanged, no done. cancel=1 together with start in IDLE -> start not accepted.
- Without it: no cancel port; every accepted operation runs to commit.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle -> hi=lo=0, busy=0, done=0 immediately.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy cycles 1..5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse in cycle 6. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- hilo_use_d=1 held from start cycle -> stall=1 in the start cycle and all 5 busy cycles, 0 in the done cycle.
- mthi wdata=0x1234 in IDLE -> hi=0x1234 next cycle. Second start issued in the done cycle -> accepted, busy next cycle.
- MDU_CANCEL_EN: cancel in busy cycle 3 of a DIV -> IDLE next cycle, HI/LO retain prior values, no done pulse.
